// File: rtl/serial_deserializer_pkg.sv
// Shared definitions for the serial receive blocks: FSM state encoding and a
// counter-width helper usable in parameter expressions.
package serial_deserializer_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    // Returns the number of bits needed to count 0 .. value-1 (at least 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_deserializer_out_hold_reg.sv
// One-word valid/ready holding register; a word offered while the slot is
// occupied and not being consumed is dropped and flagged in a sticky overrun.
module out_hold_reg #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             ready,
    input  logic             clr_ovr,
    output logic [WIDTH-1:0] dout,
    output logic             valid,
    output logic             overrun
);

    logic slot_free;

    // A slot being consumed on this edge can be refilled on the same edge.
    assign slot_free = !valid || ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout  <= '0;
            valid <= 1'b0;
        end else if (load && slot_free) begin
            dout  <= din;
            valid <= 1'b1;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

    // A new overrun wins over a simultaneous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            overrun <= 1'b0;
        end else if (load && !slot_free) begin
            overrun <= 1'b1;
        end else if (clr_ovr) begin
            overrun <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_deserializer.sv
// Reassembles WIDTH-bit words from a strobed serial stream and hands them to
// a consumer through a one-word valid/ready holding register.
module serial_deserializer
    import serial_deserializer_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = clog2(WIDTH)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic             SIN,
    input  logic             SIN_EN,
    output logic [WIDTH-1:0] DOUT,
    output logic             DOUT_VALID,
    input  logic             DOUT_READY,
    output logic             OVERRUN,
    input  logic             CLR_OVR,
    output logic             BUSY,
    output logic [CW-1:0]    BIT_CNT
);

    logic [0:0]       state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    bit_cnt;
    logic             shift_en;
    logic             word_done;

    // sr_next already contains the current SIN, so on the last bit it is the
    // complete word handed to the holding register.
    always_comb begin
        if (MSB_FIRST) begin
            sr_next = {sr[WIDTH-2:0], SIN};
        end else begin
            sr_next = {SIN, sr[WIDTH-1:1]};
        end
    end

    assign shift_en  = (state == ST_SHIFT) && !STOP && !START && SIN_EN;
    assign word_done = shift_en && (bit_cnt == CW'(WIDTH - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            sr      <= '0;
            bit_cnt <= '0;
        end else if (state == ST_IDLE) begin
            if (START) begin
                state   <= ST_SHIFT;
                sr      <= '0;
                bit_cnt <= '0;
            end
        end else if (STOP) begin
            state   <= ST_IDLE;
            sr      <= '0;
            bit_cnt <= '0;
        end else if (START) begin
            sr      <= '0;
            bit_cnt <= '0;
        end else if (SIN_EN) begin
            sr      <= sr_next;
            bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
        end
    end

    out_hold_reg #(
        .WIDTH(WIDTH)
    ) u_out_hold_reg (
        .CLK    (CLK),
        .RST    (RST),
        .load   (word_done),
        .din    (sr_next),
        .ready  (DOUT_READY),
        .clr_ovr(CLR_OVR),
        .dout   (DOUT),
        .valid  (DOUT_VALID),
        .overrun(OVERRUN)
    );

    assign BUSY    = (state == ST_SHIFT);
    assign BIT_CNT = bit_cnt;

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench: one DUT per bit order fed the same stimulus, checked
// against a bit-queue reference model of the receive path.
module tb_serial_deserializer;

    localparam int W = 4;

    logic         CLK;
    logic         RST;
    logic         START;
    logic         STOP;
    logic         SIN;
    logic         SIN_EN;
    logic         DOUT_READY;
    logic         CLR_OVR;

    logic [W-1:0] dout_m, dout_l;
    logic         valid_m, valid_l;
    logic         ovr_m, ovr_l;
    logic         busy_m, busy_l;
    logic [1:0]   cnt_m, cnt_l;

    int checks = 0;
    int errors = 0;

    // reference model state (reflects DUT state between edges)
    bit           m_busy;
    bit           m_bits[$];
    bit           m_valid;
    bit           m_ovr;
    logic [W-1:0] m_word_m, m_word_l;
    logic [W-1:0] exp_q_m[$];
    logic [W-1:0] exp_q_l[$];

    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .SIN(SIN),
        .SIN_EN(SIN_EN), .DOUT(dout_m), .DOUT_VALID(valid_m),
        .DOUT_READY(DOUT_READY), .OVERRUN(ovr_m), .CLR_OVR(CLR_OVR),
        .BUSY(busy_m), .BIT_CNT(cnt_m)
    );

    serial_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .SIN(SIN),
        .SIN_EN(SIN_EN), .DOUT(dout_l), .DOUT_VALID(valid_l),
        .DOUT_READY(DOUT_READY), .OVERRUN(ovr_l), .CLR_OVR(CLR_OVR),
        .BUSY(busy_l), .BIT_CNT(cnt_l)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy  = 0;
        m_bits.delete();
        m_valid = 0;
        m_ovr   = 0;
        m_word_m = '0;
        m_word_l = '0;
        exp_q_m.delete();
        exp_q_l.delete();
    endtask

    // Applies one clock edge worth of behaviour at the word/frame level.
    task automatic model_edge(input bit st, sp, s, se, rd, cl);
        bit           got_word;
        bit           slot_free;
        logic [W-1:0] wm, wl;
        got_word = 0;
        wm = '0;
        wl = '0;
        if (!m_busy) begin
            if (st) begin
                m_busy = 1;
                m_bits.delete();
            end
        end else if (sp) begin
            m_busy = 0;
            m_bits.delete();
        end else if (st) begin
            m_bits.delete();
        end else if (se) begin
            m_bits.push_back(s);
            if (m_bits.size() == W) begin
                for (int i = 0; i < W; i++) begin
                    wm = wm + (W'(m_bits[i]) << (W - 1 - i));
                    wl = wl + (W'(m_bits[i]) << i);
                end
                got_word = 1;
                m_bits.delete();
            end
        end
        slot_free = !m_valid || rd;
        if (m_valid && rd) m_valid = 0;
        if (got_word && slot_free) begin
            m_valid  = 1;
            m_word_m = wm;
            m_word_l = wl;
            exp_q_m.push_back(wm);
            exp_q_l.push_back(wl);
        end
        if (got_word && !slot_free) m_ovr = 1;
        else if (cl) m_ovr = 0;
    endtask

    // Drives inputs for one cycle (called just after a rising edge) and
    // advances the model across the following edge.
    task automatic applyStimulus(input bit st, sp, s, se, rd, cl);
        START = st; STOP = sp; SIN = s; SIN_EN = se; DOUT_READY = rd; CLR_OVR = cl;
        @(posedge CLK);
        #1;
        model_edge(st, sp, s, se, rd, cl);
    endtask

    task automatic send_bits(input logic [W-1:0] bits, input bit rd_last);
        for (int i = W - 1; i >= 0; i--) begin
            applyStimulus(0, 0, bits[i], 1, (i == 0) ? rd_last : 1'b0, 0);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 1, 0);
    endtask

    // Monitor: every cycle compares status against the model and pops the
    // scoreboard whenever a transfer will happen on the next edge.
    always @(negedge CLK) begin
        if (!RST) begin
            chk("valid_msb", valid_m, m_valid);
            chk("valid_lsb", valid_l, m_valid);
            chk("overrun", ovr_m, m_ovr);
            chk("busy", busy_m, m_busy);
            chk("bit_cnt", cnt_m, m_bits.size());
            chk("bit_cnt_lsb", cnt_l, m_bits.size());
            if (m_valid) begin
                chk("held_msb", dout_m, m_word_m);
                chk("held_lsb", dout_l, m_word_l);
            end
            if (valid_m && DOUT_READY) begin
                if (exp_q_m.size() == 0) chk("unexpected_msb_word", 1, 0);
                else chk("xfer_msb", dout_m, exp_q_m.pop_front());
            end
            if (valid_l && DOUT_READY) begin
                if (exp_q_l.size() == 0) chk("unexpected_lsb_word", 1, 0);
                else chk("xfer_lsb", dout_l, exp_q_l.pop_front());
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, act, exp);
    endtask

    initial begin
        bit st, sp, s, se, rd, cl;
        RST = 1; START = 0; STOP = 0; SIN = 0; SIN_EN = 0; DOUT_READY = 0; CLR_OVR = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_dout", dout_m, 0);
        checkOutput("rst_valid", valid_m, 0);
        checkOutput("rst_ovr", ovr_m, 0);
        checkOutput("rst_busy", busy_m, 0);
        checkOutput("rst_cnt", cnt_m, 0);
        RST = 0;

        // basic word, both bit orders
        applyStimulus(1, 0, 0, 0, 0, 0);
        send_bits(4'b1011, 0);
        checkOutput("word_msb", dout_m, 4'hB);
        checkOutput("word_lsb", dout_l, 4'hD);
        checkOutput("word_valid", valid_m, 1);
        checkOutput("word_ovr", ovr_m, 0);
        checkOutput("word_cnt", cnt_m, 0);
        drain();

        // back-pressure overrun, clear, then consume
        send_bits(4'hA, 0);
        send_bits(4'h5, 0);
        checkOutput("ovr_hold", dout_m, 4'hA);
        checkOutput("ovr_set", ovr_m, 1);
        applyStimulus(0, 0, 0, 0, 0, 1);
        checkOutput("ovr_clr", ovr_m, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        checkOutput("ovr_consumed", valid_m, 0);

        // simultaneous consume and refill
        send_bits(4'hF, 0);
        send_bits(4'h3, 1);
        checkOutput("refill_word", dout_m, 4'h3);
        checkOutput("refill_valid", valid_m, 1);
        checkOutput("refill_ovr", ovr_m, 0);
        drain();

        // restart discards partial bits
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(1, 0, 1, 1, 0, 0);
        send_bits(4'h6, 0);
        checkOutput("restart_word", dout_m, 4'h6);
        drain();

        // stop mid-word produces nothing
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 0, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(0, 1, 1, 1, 0, 0);
        checkOutput("stop_busy", busy_m, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("stop_valid", valid_m, 0);
        checkOutput("stop_cnt", cnt_m, 0);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            st = ($urandom_range(0, 29) == 0);
            if (!m_busy && $urandom_range(0, 3) == 0) st = 1;
            sp = ($urandom_range(0, 49) == 0);
            s  = 1'($urandom_range(0, 1));
            se = ($urandom_range(0, 9) < 7);
            rd = 1'($urandom_range(0, 1));
            cl = ($urandom_range(0, 15) == 0);
            applyStimulus(st, sp, s, se, rd, cl);
        end
        drain();

        // asynchronous reset mid-frame with a pending word and overrun
        applyStimulus(1, 0, 0, 0, 0, 0);
        send_bits(4'h9, 0);
        send_bits(4'h2, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        checkOutput("pre_rst_valid", valid_m, 1);
        checkOutput("pre_rst_ovr", ovr_m, 1);
        #2 RST = 1;
        #1;
        checkOutput("arst_dout", dout_m, 0);
        checkOutput("arst_valid", valid_m, 0);
        checkOutput("arst_ovr", ovr_m, 0);
        checkOutput("arst_busy", busy_m, 0);
        checkOutput("arst_cnt", cnt_m, 0);
        model_reset();
        @(posedge CLK);
        #1 RST = 0;

        applyStimulus(1, 0, 0, 0, 0, 0);
        send_bits(4'hC, 0);
        drain();
        checkOutput("queue_msb_empty", exp_q_m.size(), 0);
        checkOutput("queue_lsb_empty", exp_q_l.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_deserializer.md
Name: serial_deserializer

Overview:
- Receive-side neighbour of the team's 4-bit parallel-load/serial-out shift register.
- Consumes its serial bit stream (one bit per enable pulse) and reassembles WIDTH-bit words.
- Presents each word on a parallel port with a valid/ready handshake.
- A one-word output holding register decouples bit assembly from the consumer; a sticky overrun flag reports any word lost to back-pressure.

Parameters:
- WIDTH, 4, bits per word (>=2)
- MSB_FIRST, 1, 1: first received bit lands in DOUT[WIDTH-1]; 0: first received bit lands in DOUT[0]

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- START  in  1  begin (or restart) a frame; partial word discarded
- STOP  in  1  end frame, return to idle; partial word discarded
- SIN  in  1  serial data bit
- SIN_EN  in  1  SIN valid this cycle (shift strobe)
- DOUT  out  WIDTH  assembled word (holding register)
- DOUT_VALID  out  1  DOUT holds an unconsumed word
- DOUT_READY  in  1  consumer accepts DOUT when DOUT_VALID=1
- OVERRUN  out  1  sticky: a completed word was dropped
- CLR_OVR  in  1  synchronous clear of OVERRUN
- BUSY  out  1  FSM in SHIFT state
- BIT_CNT  out  $clog2(WIDTH)  bits collected in current word

Behaviour:
- Reset (async, RST=1): state IDLE; shift reg=0; BIT_CNT=0; DOUT=0; DOUT_VALID=0; OVERRUN=0; BUSY=0. Reset mid-frame or with a pending word discards everything.
- FSM, two states:
  - IDLE: SIN_EN ignored. START -> SHIFT with BIT_CNT=0; no bit is captured on the START cycle.
  - SHIFT: STOP -> IDLE, BIT_CNT=0, partial word dropped. STOP has priority over START and SIN_EN. START (without STOP) -> stay in SHIFT, BIT_CNT=0, SIN_EN ignored that cycle. Otherwise SIN_EN shifts SIN in and increments BIT_CNT. The FSM stays in SHIFT across words (continuous stream).
- Shift direction:
  - MSB_FIRST=1: sr <= {sr[WIDTH-2:0], SIN}.
  - MSB_FIRST=0: sr <= {SIN, sr[WIDTH-1:1]}.
- Word completion: SIN_EN with BIT_CNT==WIDTH-1.
  - The completed word (sr combined with the current SIN) is the transfer candidate.
  - BIT_CNT wraps to 0 on the same edge.
- Output slot is free when DOUT_VALID==0, or when DOUT_VALID==1 and DOUT_READY==1 in the same cycle (simultaneous consume and refill).
- If the slot is free: DOUT <= word and DOUT_VALID=1 after that edge. Latency is one edge from the last bit's SIN_EN cycle to DOUT_VALID high.
- If the slot is not free: the word is dropped, DOUT is unchanged, and OVERRUN is set (sticky).
- Handshake:
  - Transfer occurs on an edge with DOUT_VALID & DOUT_READY.
  - DOUT_VALID clears after that edge unless refilled the same cycle.
  - DOUT is stable while DOUT_VALID=1 and not accepted.
  - DOUT_READY while DOUT_VALID=0 has no effect.
- OVERRUN:
  - CLR_OVR clears it.
  - If CLR_OVR and a new overrun occur on the same edge, the set wins (OVERRUN=1).
- STOP or START do not affect DOUT/DOUT_VALID; a pending word survives the end of a frame.
- BUSY = (state==SHIFT), registered.

Decomposition:
- Shared package: state encoding constants (ST_IDLE, ST_SHIFT) and a counter-width function (clog2) for reuse by sibling serial blocks.
- One natural sub-module: out_hold_reg, the WIDTH-bit valid/ready holding register with overrun detect. The FSM and shift register stay in the top module.

Test Plan:
- Reset, then START, then SIN_EN bits 1,0,1,1 on consecutive cycles with MSB_FIRST=1 -> DOUT=4'hB and DOUT_VALID=1 one edge after the 4th bit; OVERRUN=0; BIT_CNT back to 0.
- Same bit sequence with MSB_FIRST=0 -> DOUT=4'hD.
- DOUT_READY held 0, two full words 4'hA then 4'h5 -> DOUT stays 4'hA, OVERRUN=1; assert CLR_OVR -> OVERRUN=0; DOUT_READY=1 -> DOUT_VALID=0 next edge.
- DOUT_VALID=1 with DOUT_READY=1 on the same cycle as the 4th bit of word 4'h3 -> no overrun, DOUT=4'h3, DOUT_VALID stays 1.
- Two bits received, then START, then 4 bits 0,1,1,0 -> DOUT=4'h6, the first partial bits discarded. Separately, STOP after 3 bits -> IDLE, BUSY=0, and no word is produced.
- Assert RST asynchronously mid-frame with DOUT_VALID=1 -> all outputs 0 immediately, without waiting for a CLK edge.
